// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer
//
// Purpose:
//   Timing and control unit for the basic-computer datapath (AC/AR/DR/IR/PC/
//   RAM). It owns the sequence counter (SC) and the run flag. From the current
//   T state, the IR contents and the datapath flags it generates the micro-op
//   strobes, the common-bus source select and the RAM read/write requests for
//   each cycle.
//   Memory T states hold the sequence counter until the RAM reports
//   mem_ready. Load and increment strobes in a memory state fire only in the
//   completion cycle.
//
// Parameters:
//   ADDR_W : address field width (>= 8). The instruction is 1+3+ADDR_W bits:
//            {I, opcode[2:0], address / micro-op field B}.
//   SC_W   : sequence counter width. States T0..T6 must fit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ir                  IR contents
//   mem_ready           RAM finishes the current read/write this cycle
//   dr_zero, ac_zero    datapath zero flags
//   ac_neg              AC sign bit
//   start               one-cycle pulse that leaves the halted state
//   t_state             one-hot current T state (T0..T7)
//   halted              run flag is low
//   ld_ac .. inr_pc     micro-op strobes
//   ac_op               AC function, valid with ld_ac
//                       (0 AND, 1 ADD, 2 LOAD, 3 CMA, 4 CIR, 5 CIL)
//   sel                 bus source
//                       (0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM)
//   mem_rd, mem_wr      RAM requests
//
// Optional feature (macro INTERRUPT_EN):
//   Adds the irq input, the ld_tr/clr_ar/clr_pc outputs, the interrupt
//   enable flag (ien) and the interrupt request flag (r). It also adds the
//   interrupt cycle RT0..RT2 and the ION/IOF instructions. Without the macro,
//   I=1/op=7 always decodes as HLT.
// ============================================================================
module control_sequencer #(
    parameter int ADDR_W = 8,
    parameter int SC_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W+3:0] ir,
    input  logic              mem_ready,
    input  logic              dr_zero,
    input  logic              ac_zero,
    input  logic              ac_neg,
    input  logic              start,
`ifdef INTERRUPT_EN
    input  logic              irq,
`endif
    output logic [7:0]        t_state,
    output logic              halted,
    output logic              ld_ac,
    output logic              clr_ac,
    output logic              inr_ac,
    output logic              ld_ar,
    output logic              inr_ar,
    output logic              ld_dr,
    output logic              inr_dr,
    output logic              ld_ir,
    output logic              ld_pc,
    output logic              inr_pc,
    output logic [2:0]        ac_op,
    output logic [2:0]        sel,
`ifdef INTERRUPT_EN
    output logic              ld_tr,
    output logic              clr_ar,
    output logic              clr_pc,
`endif
    output logic              mem_rd,
    output logic              mem_wr
);

    localparam logic [SC_W-1:0] T0 = SC_W'(0);
    localparam logic [SC_W-1:0] T1 = SC_W'(1);
    localparam logic [SC_W-1:0] T2 = SC_W'(2);
    localparam logic [SC_W-1:0] T3 = SC_W'(3);
    localparam logic [SC_W-1:0] T4 = SC_W'(4);
    localparam logic [SC_W-1:0] T5 = SC_W'(5);
    localparam logic [SC_W-1:0] T6 = SC_W'(6);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_AR   = 3'd1;
    localparam logic [2:0] SEL_PC   = 3'd2;
    localparam logic [2:0] SEL_DR   = 3'd3;
    localparam logic [2:0] SEL_AC   = 3'd4;
    localparam logic [2:0] SEL_IR   = 3'd5;
    localparam logic [2:0] SEL_MEM  = 3'd7;

    localparam logic [2:0] OP_CMA = 3'd3;
    localparam logic [2:0] OP_CIR = 3'd4;
    localparam logic [2:0] OP_CIL = 3'd5;

    typedef enum logic {
        RUN_STATE  = 1'b0,
        HALT_STATE = 1'b1
    } run_t;

    run_t            run_q;
    logic [SC_W-1:0] sc_q;

    logic              i_bit;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] fld_b;

    logic sc_adv;
    logic sc_clr;
    logic do_halt;
    logic intr_cycle;

`ifdef INTERRUPT_EN
    localparam logic [2:0] SEL_TR = 3'd6;

    logic ien_q;
    logic r_q;
    logic ien_set;
    logic ien_clr;
    logic r_set;
    logic r_clr;
`endif

    // Instruction fields. Decode is taken straight from ir. This is only
    // meaningful from T2 onward, once IR has been loaded by the fetch.
    assign i_bit  = ir[ADDR_W+3];
    assign opcode = ir[ADDR_W+2:ADDR_W];
    assign fld_b  = ir[ADDR_W-1:0];

    assign halted  = (run_q == HALT_STATE);
    assign t_state = 8'h01 << sc_q;

    // The interrupt cycle reuses SC values 0..2. The request flag r is set
    // only during T3..T6 and is cleared at RT2, so r together with a low SC
    // identifies RT0..RT2 without a separate mode bit.
`ifdef INTERRUPT_EN
    assign intr_cycle = r_q && (sc_q <= T2);
`else
    assign intr_cycle = 1'b0;
`endif

    // Control decode. The strobes cannot be registered, because a memory
    // state must react to mem_ready in the same cycle. They are therefore
    // decoded from the registered SC and run flag plus the live inputs.
    // sc_adv and sc_clr both low means the SC holds (memory stall).
    always_comb begin
        ld_ac   = 1'b0;
        clr_ac  = 1'b0;
        inr_ac  = 1'b0;
        ld_ar   = 1'b0;
        inr_ar  = 1'b0;
        ld_dr   = 1'b0;
        inr_dr  = 1'b0;
        ld_ir   = 1'b0;
        ld_pc   = 1'b0;
        inr_pc  = 1'b0;
        ac_op   = 3'd0;
        sel     = SEL_NONE;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        sc_adv  = 1'b0;
        sc_clr  = 1'b0;
        do_halt = 1'b0;
`ifdef INTERRUPT_EN
        ld_tr   = 1'b0;
        clr_ar  = 1'b0;
        clr_pc  = 1'b0;
        ien_set = 1'b0;
        ien_clr = 1'b0;
        r_clr   = 1'b0;
`endif
        if (run_q == RUN_STATE) begin
            if (intr_cycle) begin
`ifdef INTERRUPT_EN
                case (sc_q)
                    T0: begin
                        clr_ar = 1'b1;
                        sel    = SEL_PC;
                        ld_tr  = 1'b1;
                        sc_adv = 1'b1;
                    end
                    T1: begin
                        mem_wr = 1'b1;
                        sel    = SEL_TR;
                        if (mem_ready) begin
                            clr_pc = 1'b1;
                            sc_adv = 1'b1;
                        end
                    end
                    default: begin
                        inr_pc  = 1'b1;
                        ien_clr = 1'b1;
                        r_clr   = 1'b1;
                        sc_clr  = 1'b1;
                    end
                endcase
`endif
            end else begin
                case (sc_q)
                    T0: begin
                        sel    = SEL_PC;
                        ld_ar  = 1'b1;
                        sc_adv = 1'b1;
                    end
                    T1: begin
                        mem_rd = 1'b1;
                        sel    = SEL_MEM;
                        if (mem_ready) begin
                            ld_ir  = 1'b1;
                            inr_pc = 1'b1;
                            sc_adv = 1'b1;
                        end
                    end
                    T2: begin
                        sel    = SEL_IR;
                        ld_ar  = 1'b1;
                        sc_adv = 1'b1;
                    end
                    T3: begin
                        if (opcode == 3'd7 && !i_bit) begin
                            // Register reference: only one AC action is
                            // honoured. All selected skip tests OR together.
                            if (fld_b[3]) begin
                                clr_ac = 1'b1;
                            end else if (fld_b[2]) begin
                                ld_ac = 1'b1;
                                ac_op = OP_CMA;
                            end else if (fld_b[1]) begin
                                ld_ac = 1'b1;
                                ac_op = OP_CIR;
                            end else if (fld_b[0]) begin
                                ld_ac = 1'b1;
                                ac_op = OP_CIL;
                            end else if (fld_b[4]) begin
                                inr_ac = 1'b1;
                            end
                            inr_pc = (fld_b[5] & ~ac_neg) | (fld_b[6] & ac_neg) |
                                     (fld_b[7] & ac_zero);
                            sc_clr = 1'b1;
                        end else if (opcode == 3'd7) begin
`ifdef INTERRUPT_EN
                            if (fld_b[7]) begin
                                ien_set = 1'b1;
                            end else if (fld_b[6]) begin
                                ien_clr = 1'b1;
                            end else if (fld_b == '0) begin
                                do_halt = 1'b1;
                            end
`else
                            do_halt = 1'b1;
`endif
                            sc_clr = 1'b1;
                        end else if (i_bit) begin
                            // Indirect: fetch the effective address into AR.
                            mem_rd = 1'b1;
                            sel    = SEL_MEM;
                            if (mem_ready) begin
                                ld_ar  = 1'b1;
                                sc_adv = 1'b1;
                            end
                        end else begin
                            sc_adv = 1'b1;
                        end
                    end
                    T4: begin
                        case (opcode)
                            3'd0, 3'd1, 3'd2, 3'd6: begin
                                mem_rd = 1'b1;
                                sel    = SEL_MEM;
                                if (mem_ready) begin
                                    ld_dr  = 1'b1;
                                    sc_adv = 1'b1;
                                end
                            end
                            3'd3: begin
                                mem_wr = 1'b1;
                                sel    = SEL_AC;
                                if (mem_ready) begin
                                    sc_clr = 1'b1;
                                end
                            end
                            3'd4: begin
                                sel    = SEL_AR;
                                ld_pc  = 1'b1;
                                sc_clr = 1'b1;
                            end
                            3'd5: begin
                                // BSA stores the return address at M[AR],
                                // then steps AR to the subroutine body.
                                mem_wr = 1'b1;
                                sel    = SEL_PC;
                                if (mem_ready) begin
                                    inr_ar = 1'b1;
                                    sc_adv = 1'b1;
                                end
                            end
                            default: sc_clr = 1'b1;
                        endcase
                    end
                    T5: begin
                        case (opcode)
                            3'd0, 3'd1, 3'd2: begin
                                ld_ac  = 1'b1;
                                ac_op  = opcode;
                                sc_clr = 1'b1;
                            end
                            3'd5: begin
                                sel    = SEL_AR;
                                ld_pc  = 1'b1;
                                sc_clr = 1'b1;
                            end
                            3'd6: begin
                                inr_dr = 1'b1;
                                sc_adv = 1'b1;
                            end
                            default: sc_clr = 1'b1;
                        endcase
                    end
                    T6: begin
                        if (opcode == 3'd6) begin
                            mem_wr = 1'b1;
                            sel    = SEL_DR;
                            if (mem_ready) begin
                                inr_pc = dr_zero;
                                sc_clr = 1'b1;
                            end
                        end else begin
                            sc_clr = 1'b1;
                        end
                    end
                    default: sc_clr = 1'b1;
                endcase
            end
        end
    end

`ifdef INTERRUPT_EN
    // An interrupt is latched at the end of any execute cycle (T3..T6),
    // stalled ones included, so it is seen at the next T0.
    assign r_set = ien_q && irq && !intr_cycle && (sc_q >= T3) && (sc_q <= T6);
`endif

    // Sequence counter and run flag. The reset branch comes first, so rst
    // wins over a simultaneous start. While halted, SC is pinned at 0.
    // start is only looked at in the halted state.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= HALT_STATE;
            sc_q  <= T0;
`ifdef INTERRUPT_EN
            ien_q <= 1'b0;
            r_q   <= 1'b0;
`endif
        end else if (run_q == HALT_STATE) begin
            sc_q <= T0;
            if (start) begin
                run_q <= RUN_STATE;
            end
        end else begin
            if (do_halt) begin
                run_q <= HALT_STATE;
            end
            if (sc_clr) begin
                sc_q <= T0;
            end else if (sc_adv) begin
                sc_q <= sc_q + SC_W'(1);
            end
`ifdef INTERRUPT_EN
            if (ien_clr) begin
                ien_q <= 1'b0;
            end else if (ien_set) begin
                ien_q <= 1'b1;
            end
            if (r_clr) begin
                r_q <= 1'b0;
            end else if (r_set) begin
                r_q <= 1'b1;
            end
`endif
        end
    end

endmodule
